// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit seven-segment display.
// Captures the whole display value once per frame; adds LZ blanking, blink and invalid-BCD suppression.
module display_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_TICKS = 250,
  parameter int unsigned CNT_W       = 17
) (
  input  logic        src_clk,
  input  logic        src_rst,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  blink_mask,
  input  logic        lz_en,
  output logic [1:0]  select,
  output logic [3:0]  digit_val,
  output logic        dp,
  output logic        digit_on,
  output logic        frame_start
);

  localparam int unsigned BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  typedef enum logic {
    S_LOAD,
    S_RUN
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] pre_cnt, pre_cnt_n;
  logic [BLK_W-1:0] blink_cnt, blink_cnt_n;
  logic             blink_phase, blink_phase_n;
  logic [15:0]      sh_digits, sh_digits_n;
  logic [3:0]       sh_dp, sh_dp_n;
  logic [3:0]       sh_blink, sh_blink_n;
  logic [1:0]       select_n;
  logic [3:0]       digit_val_n;
  logic             dp_n, digit_on_n, frame_start_n;

  logic             tick, capture, update;
  logic [3:0]       slot_val;
  logic             slot_dp, slot_on, lz_blank;

  always_ff @(posedge src_clk) begin
    if (src_rst) begin
      state       <= S_LOAD;
      pre_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      sh_digits   <= '0;
      sh_dp       <= '0;
      sh_blink    <= '0;
      select      <= '0;
      digit_val   <= '0;
      dp          <= 1'b0;
      digit_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      pre_cnt     <= pre_cnt_n;
      blink_cnt   <= blink_cnt_n;
      blink_phase <= blink_phase_n;
      sh_digits   <= sh_digits_n;
      sh_dp       <= sh_dp_n;
      sh_blink    <= sh_blink_n;
      select      <= select_n;
      digit_val   <= digit_val_n;
      dp          <= dp_n;
      digit_on    <= digit_on_n;
      frame_start <= frame_start_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_LOAD:  state_n = S_RUN;
      S_RUN:   state_n = S_RUN;
      default: state_n = S_RUN;
    endcase

    tick      = (pre_cnt == CNT_W'(REFRESH_DIV - 1));
    pre_cnt_n = tick ? '0 : pre_cnt + 1'b1;

    capture = (state == S_LOAD) || (tick && (select == 2'd3));
    update  = (state == S_LOAD) || tick;

    sh_digits_n = capture ? digits     : sh_digits;
    sh_dp_n     = capture ? dp_mask    : sh_dp;
    sh_blink_n  = capture ? blink_mask : sh_blink;

    blink_cnt_n   = blink_cnt;
    blink_phase_n = blink_phase;
    if (tick) begin
      if (blink_cnt == BLK_W'(BLINK_TICKS - 1)) begin
        blink_cnt_n   = '0;
        blink_phase_n = ~blink_phase;
      end else begin
        blink_cnt_n = blink_cnt + 1'b1;
      end
    end

    select_n      = tick ? select + 2'd1 : select;
    frame_start_n = tick && (select == 2'd3);

    // Slot outputs use the post-edge shadow and phase so a wrap shows the fresh frame.
    slot_val = sh_digits_n[{select_n, 2'b00} +: 4];
    slot_dp  = sh_dp_n[select_n];
    lz_blank = lz_en && (select_n != 2'd0);
    for (int unsigned i = 0; i < 4; i++) begin
      if ((i >= 32'(select_n)) && (sh_digits_n[i*4 +: 4] != 4'd0)) lz_blank = 1'b0;
    end
    slot_on = !(blink_phase_n && sh_blink_n[select_n]) && !lz_blank && (slot_val <= 4'd9);

    digit_val_n = update ? slot_val : digit_val;
    dp_n        = update ? slot_dp  : dp;
    digit_on_n  = update ? slot_on  : digit_on;
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: cycle scoreboard against a reference model, vector table, corner sequences.
module tb_display_scan_ctrl;

  localparam int unsigned RD = 4;
  localparam int unsigned BT = 3;

  logic        src_clk = 1'b0;
  logic        src_rst = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic        lz_en = 1'b0;
  logic [1:0]  select;
  logic [3:0]  digit_val;
  logic        dp, digit_on, frame_start;

  int checks = 0;
  int errors = 0;

  display_scan_ctrl #(.REFRESH_DIV(RD), .BLINK_TICKS(BT), .CNT_W(3)) dut (
    .src_clk(src_clk), .src_rst(src_rst), .digits(digits), .dp_mask(dp_mask),
    .blink_mask(blink_mask), .lz_en(lz_en), .select(select), .digit_val(digit_val),
    .dp(dp), .digit_on(digit_on), .frame_start(frame_start)
  );

  always #5 src_clk = ~src_clk;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] val;
    logic       dp;
    logic       on;
    logic       fs;
  } obs_t;

  obs_t exp_q[$];

  int unsigned m_pre, m_bc;
  logic [1:0]  m_sel;
  logic        m_ph, m_lp;
  logic [15:0] m_dig;
  logic [3:0]  m_dpm, m_blm;
  obs_t        m_out;

  function automatic obs_t slot_view(input logic [1:0] s, input logic fs);
    obs_t o;
    int   k;
    logic lzb;
    k     = int'(s);
    o.sel = s;
    o.val = m_dig[k*4 +: 4];
    o.dp  = m_dpm[k];
    o.fs  = fs;
    lzb   = lz_en && (k != 0) && ((m_dig >> (4 * k)) == 16'h0);
    o.on  = !(m_ph && m_blm[k]) && !lzb && (o.val <= 4'd9);
    return o;
  endfunction

  // Reference model: one expected observation pushed per clock edge.
  initial begin : model
    logic tk, fs;
    forever begin
      @(posedge src_clk);
      if (src_rst) begin
        m_pre = 0; m_bc = 0; m_sel = 2'd0; m_ph = 1'b0; m_lp = 1'b1;
        m_dig = '0; m_dpm = '0; m_blm = '0; m_out = '0;
      end else begin
        tk = (m_pre == RD - 1);
        m_pre = tk ? 0 : m_pre + 1;
        m_out.fs = 1'b0;
        if (m_lp) begin
          m_dig = digits; m_dpm = dp_mask; m_blm = blink_mask; m_lp = 1'b0;
          m_out = slot_view(m_sel, 1'b0);
        end else if (tk) begin
          fs = (m_sel == 2'd3);
          if (fs) begin
            m_dig = digits; m_dpm = dp_mask; m_blm = blink_mask;
          end
          if (m_bc == BT - 1) begin
            m_bc = 0; m_ph = !m_ph;
          end else begin
            m_bc = m_bc + 1;
          end
          m_sel = m_sel + 2'd1;
          m_out = slot_view(m_sel, fs);
        end
      end
      exp_q.push_back(m_out);
    end
  end

  initial begin : checker_proc
    obs_t e, got;
    forever begin
      @(posedge src_clk);
      #1;
      got = {select, digit_val, dp, digit_on, frame_start};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t got sel=%0d val=%h dp=%b on=%b fs=%b exp sel=%0d val=%h dp=%b on=%b fs=%b",
                   $time, got.sel, got.val, got.dp, got.on, got.fs, e.sel, e.val, e.dp, e.on, e.fs);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick_wait(input int n);
    repeat (n) @(posedge src_clk);
    #1;
  endtask

  task automatic wait_fs();
    for (int i = 0; i < 40; i++) begin
      @(posedge src_clk);
      #1;
      if (frame_start) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_frame_start timeout got=0 exp=1");
  endtask

  task automatic wait_sel(input logic [1:0] s);
    for (int i = 0; i < 40; i++) begin
      @(posedge src_clk);
      #1;
      if (select == s) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_select timeout got=%0d exp=%0d", select, s);
  endtask

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  dpm;
    logic        lz;
    logic [15:0] exp_val;
    logic [3:0]  exp_on;
    logic [3:0]  exp_dp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int blank0, blank1, blank2;
    vecs[0] = '{16'h1234, 4'b0000, 1'b0, 16'h1234, 4'b1111, 4'b0000};
    vecs[1] = '{16'h0007, 4'b0000, 1'b1, 16'h0007, 4'b0001, 4'b0000};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, 16'h0000, 4'b0001, 4'b0000};
    vecs[3] = '{16'h0100, 4'b0000, 1'b1, 16'h0100, 4'b0111, 4'b0000};
    vecs[4] = '{16'h00A5, 4'b0100, 1'b0, 16'h00A5, 4'b1101, 4'b0100};
    vecs[5] = '{16'h0159, 4'b1111, 1'b1, 16'h0159, 4'b0111, 4'b1111};
    vecs[6] = '{16'hF000, 4'b0000, 1'b1, 16'hF000, 4'b0111, 4'b0000};
    vecs[7] = '{16'h9999, 4'b1010, 1'b0, 16'h9999, 4'b1111, 4'b1010};

    digits = 16'h1234;
    tick_wait(3);
    check("reset_outputs", 32'({select, digit_val, dp, digit_on, frame_start}), 32'h0);
    @(negedge src_clk);
    src_rst = 1'b0;
    tick_wait(1);
    check("load_cycle_val", 32'({select, digit_val, digit_on}), 32'({2'd0, 4'd4, 1'b1}));

    for (int v = 0; v < 8; v++) begin
      @(negedge src_clk);
      digits = vecs[v].dig; dp_mask = vecs[v].dpm; lz_en = vecs[v].lz; blink_mask = '0;
      wait_fs();
      for (int s = 0; s < 4; s++) begin
        if (s != 0) tick_wait(RD);
        check($sformatf("vec%0d_slot%0d", v, s),
              32'({select, digit_val, digit_on, dp}),
              32'({2'(s), vecs[v].exp_val[s*4 +: 4], vecs[v].exp_on[s], vecs[v].exp_dp[s]}));
      end
    end

    // Tear-free capture: change the input while slot 1 is on screen.
    @(negedge src_clk);
    digits = 16'h0159; dp_mask = '0; lz_en = 1'b0;
    wait_fs();
    tick_wait(RD);
    check("tear_sel1", 32'({select, digit_val}), 32'({2'd1, 4'd5}));
    @(negedge src_clk);
    digits = 16'h0200;
    wait_sel(2'd2);
    check("tear_slot2_old", 32'(digit_val), 32'd1);
    tick_wait(RD);
    check("tear_slot3_old", 32'({select, digit_val}), 32'({2'd3, 4'd0}));
    tick_wait(RD);
    check("tear_slot0_new", 32'({select, digit_val, frame_start}), 32'({2'd0, 4'd0, 1'b1}));
    tick_wait(RD);
    check("tear_slot1_new", 32'(digit_val), 32'd0);
    tick_wait(RD);
    check("tear_slot2_new", 32'(digit_val), 32'd2);
    tick_wait(RD);
    check("tear_slot3_new", 32'(digit_val), 32'd0);

    // Blink on slots 0 and 1 only.
    @(negedge src_clk);
    digits = 16'h1234; blink_mask = 4'b0011;
    blank0 = 0; blank1 = 0; blank2 = 0;
    for (int c = 0; c < 24 * 4 * RD; c++) begin
      tick_wait(1);
      if (!digit_on && select == 2'd0) blank0++;
      if (!digit_on && select == 2'd1) blank1++;
      if (!digit_on && select == 2'd2) blank2++;
    end
    check("blink_slot0_blanks", 32'(blank0 > 0), 32'd1);
    check("blink_slot1_blanks", 32'(blank1 > 0), 32'd1);
    check("blink_slot2_lit", 32'(blank2), 32'd0);
    @(negedge src_clk);
    blink_mask = '0;

    // Reset in the middle of a frame.
    wait_sel(2'd2);
    @(negedge src_clk);
    src_rst = 1'b1; digits = 16'h0042; lz_en = 1'b1;
    tick_wait(1);
    check("midrst_state", 32'({select, digit_val, digit_on, frame_start}), 32'h0);
    @(negedge src_clk);
    src_rst = 1'b0;
    tick_wait(1);
    check("midrst_capture", 32'({select, digit_val, digit_on}), 32'({2'd0, 4'd2, 1'b1}));
    tick_wait(2);
    check("midrst_hold", 32'(select), 32'd0);
    tick_wait(1);
    check("midrst_prescaler", 32'({select, digit_val, digit_on}), 32'({2'd1, 4'd4, 1'b1}));

    tick_wait(3 * 4 * RD);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
